// File: rtl/mem_initiator.sv
`timescale 1ns/1ps
// mem_initiator: clocked bus master for the asynchronous en/MFC memory strobe
// interface. Takes one request at a time over valid/ready, runs the four-phase
// en/MFC handshake against a synchronized MFC, and returns a one-cycle response
// pulse carrying read data and a timeout flag. All outputs are registered.
module mem_initiator #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_rw,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          busy,
  output logic          mem_en,
  output logic          mem_rw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_mfc
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_STROBE  = 3'd2,
    S_RELEASE = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            mfc_meta_q;
  logic            mfc_s_q;

  logic            req_ready_q, req_ready_d;
  logic            busy_q, busy_d;
  logic            mem_en_q, mem_en_d;
  logic            mem_rw_q, mem_rw_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;

  // Two-flop synchronizer bringing the asynchronous MFC into the clock domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      mfc_meta_q <= 1'b0;
      mfc_s_q    <= 1'b0;
    end else begin
      mfc_meta_q <= mem_mfc;
      mfc_s_q    <= mfc_meta_q;
    end
  end

  // Next-state logic for the handshake sequencer and its registered outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    mem_rw_d    = mem_rw_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_rdata_d = rsp_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          mem_rw_d    = req_rw;
          mem_addr_d  = req_addr;
          mem_wdata_d = req_wdata;
          state_d     = S_SETUP;
        end else begin
          state_d     = S_IDLE;
        end
      end
      S_SETUP: begin
        // A still-high MFC (e.g. left over from an aborted transfer) must
        // drain before a new strobe is issued.
        if (!mfc_s_q) begin
          cnt_d   = '0;
          state_d = S_STROBE;
        end else begin
          state_d = S_SETUP;
        end
      end
      S_STROBE: begin
        // MFC is checked ahead of the counter so a completion that coincides
        // with the last timeout cycle still counts as success.
        if (mfc_s_q) begin
          if (mem_rw_q) begin
            rsp_rdata_d = mem_rdata;
          end else begin
            rsp_rdata_d = rsp_rdata_q;
          end
          cnt_d   = '0;
          state_d = S_RELEASE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_RELEASE;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      S_RELEASE: begin
        if (!mfc_s_q) begin
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      S_RESP: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        err_d   = 1'b0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    // Outputs are derived from the state being entered so they are
    // registered yet line up with that state.
    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    mem_en_d    = (state_d == S_STROBE);
    rsp_valid_d = (state_d == S_RESP);
    rsp_err_d   = (state_d == S_RESP) && err_d;
  end

  // State, counter, error flag and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      mem_en_q    <= mem_en_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign mem_en    = mem_en_q;
  assign mem_rw    = mem_rw_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_initiator.sv
`timescale 1ns/1ps
// Self-checking bench for mem_initiator: behavioural asynchronous memory with
// programmable MFC delay, a reference memory image and latency rules derived
// from the handshake timing, directed scenarios followed by random traffic.
module tb_mem_initiator;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 8;

  logic          clk       = 1'b0;
  logic          reset     = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_rw    = 1'b0;
  logic [AW-1:0] req_addr  = 16'h0000;
  logic [DW-1:0] req_wdata = 16'h0000;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          busy;
  logic          mem_en;
  logic          mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = 16'h0000;
  logic          mem_mfc   = 1'b0;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc_cnt  = 0;
  int en_rises = 0;
  int en_hi_cyc = 0;
  logic en_prev = 1'b0;

  // Per-transfer memory behaviour, consumed at each mem_en rise.
  int dly_q[$];
  bit nev_q[$];

  logic [DW-1:0] mem_model [0:65535];
  logic [DW-1:0] ref_mem   [0:65535];
  logic [DW-1:0] last_rdata = 16'h0000;

  int            m_d;
  bit            m_nv;
  logic          m_rw    = 1'b0;
  logic [AW-1:0] m_addr  = 16'h0000;
  logic [DW-1:0] m_wdata = 16'h0000;

  mem_initiator #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rw    (req_rw),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .mem_en    (mem_en),
    .mem_rw    (mem_rw),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_mfc   (mem_mfc)
  );

  // 10 ns clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Cycle counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Independent count of handshake accepts.
  always @(posedge clk) begin
    if (!reset && req_valid && req_ready) acc_cnt <= acc_cnt + 1;
  end

  // Length of the most recent mem_en high period, in clock cycles.
  always @(negedge clk) begin
    if (mem_en) en_hi_cyc <= en_prev ? en_hi_cyc + 1 : 1;
    en_prev <= mem_en;
  end

  // Asynchronous memory: acts on en rise, raises MFC after a delay (or never),
  // drives junk read data until MFC, drops MFC when en falls.
  always @(mem_en) begin
    if (mem_en === 1'b1) begin
      en_rises = en_rises + 1;
      if (dly_q.size() > 0) begin
        m_d  = dly_q.pop_front();
        m_nv = nev_q.pop_front();
      end else begin
        m_d  = 0;
        m_nv = 1'b1;
      end
      m_rw      = mem_rw;
      m_addr    = mem_addr;
      m_wdata   = mem_wdata;
      mem_rdata = 16'($urandom);
      if (!m_nv) begin
        #(m_d);
        if (mem_en === 1'b1) begin
          if (m_rw) mem_rdata = mem_model[m_addr];
          else      mem_model[m_addr] = m_wdata;
          mem_mfc = 1'b1;
        end
      end
    end else begin
      mem_mfc = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Issue one request and check its response. Expected values come from the
  // reference image; latency follows from the MFC delay: MFC is seen through
  // two flops, so success lands dly/10+3 cycles into the strobe, release takes
  // 3 more, plus SETUP and the RESP edge. A missing MFC times out after TO.
  task automatic issue(input logic rw, input logic [15:0] addr, input logic [15:0] wdata,
                       input int dly, input bit nev, input bit hold);
    logic [15:0] exp_data;
    logic        exp_err;
    int          exp_lat, exp_hi, n, acc, rises0;
    bit          got;
    exp_err  = nev;
    exp_data = (rw && !nev) ? ref_mem[addr] : last_rdata;
    exp_lat  = nev ? TO + 2 : dly / 10 + 7;
    exp_hi   = nev ? TO : dly / 10 + 3;
    req_rw    = rw;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", 32'(n < 100), 32'd1);
    rises0 = en_rises;
    @(posedge clk);
    #1;
    acc = cyc;
    dly_q.push_back(dly);
    nev_q.push_back(nev);
    if (!hold) req_valid = 1'b0;
    got = 1'b0;
    n = 0;
    while (!got && n < 100) begin
      @(negedge clk);
      n++;
      if (rsp_valid) begin
        got = 1'b1;
      end else begin
        check("hold_addr", mem_addr, addr);
        check("hold_rw", mem_rw, rw);
        check("hold_wdata", mem_wdata, wdata);
        check("ready_low", req_ready, 1'b0);
        check("busy_high", busy, 1'b1);
      end
    end
    check("rsp_seen", got, 1'b1);
    check("rsp_data", rsp_rdata, exp_data);
    check("rsp_err", rsp_err, exp_err);
    check("latency", cyc - acc, exp_lat);
    check("en_rises", en_rises - rises0, 1);
    check("en_high", en_hi_cyc, exp_hi);
    check("resp_addr", mem_addr, addr);
    if (!nev) begin
      if (rw) last_rdata = ref_mem[addr];
      else    ref_mem[addr] = wdata;
    end
  endtask

  initial begin
    logic [15:0] v;
    int          acc0, gap, n_rand;
    bit          rw_r, nev_r;

    for (int i = 0; i < 65536; i++) begin
      v = (i < 256) ? 16'($urandom) : 16'h0000;
      mem_model[i] = v;
      ref_mem[i]   = v;
    end
    mem_model[0] = 16'h50A3; ref_mem[0] = 16'h50A3;
    mem_model[1] = 16'h0081; ref_mem[1] = 16'h0081;
    mem_model[2] = 16'h4102; ref_mem[2] = 16'h4102;
    mem_model[3] = 16'h111D; ref_mem[3] = 16'h111D;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", req_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_en", mem_en, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_addr", mem_addr, 16'h0000);
    check("rst_rdata", rsp_rdata, 16'h0000);
    reset = 1'b0;
    @(negedge clk);

    // Write then read back
    issue(1'b0, 16'h0010, 16'hBEEF, 5, 1'b0, 1'b0);
    check("wr_rw", m_rw, 1'b0);
    check("wr_data", m_wdata, 16'hBEEF);
    @(negedge clk);
    issue(1'b1, 16'h0010, 16'h0000, 5, 1'b0, 1'b0);
    check("rd_beef", rsp_rdata, 16'hBEEF);

    // Program-image read at address zero
    @(negedge clk);
    issue(1'b1, 16'h0000, 16'h0000, 5, 1'b0, 1'b0);
    check("rd_image", rsp_rdata, 16'h50A3);

    // Back-to-back with req_valid held high
    @(negedge clk);
    acc0 = acc_cnt;
    issue(1'b1, 16'h0001, 16'h0000, 5, 1'b0, 1'b1);
    check("b2b_0081", rsp_rdata, 16'h0081);
    issue(1'b1, 16'h0002, 16'h0000, 5, 1'b0, 1'b1);
    check("b2b_4102", rsp_rdata, 16'h4102);
    issue(1'b1, 16'h0003, 16'h0000, 5, 1'b0, 1'b0);
    check("b2b_111D", rsp_rdata, 16'h111D);
    repeat (3) @(negedge clk);
    check("b2b_accepts", acc_cnt - acc0, 3);

    // Timeout, then a good transfer
    issue(1'b1, 16'h0003, 16'h0000, 0, 1'b1, 1'b0);
    @(negedge clk);
    issue(1'b1, 16'h0002, 16'h0000, 5, 1'b0, 1'b0);

    // Slow memory, and MFC arriving on the last timeout cycle
    @(negedge clk);
    issue(1'b1, 16'h0001, 16'h0000, 35, 1'b0, 1'b0);
    @(negedge clk);
    issue(1'b1, 16'h0003, 16'h0000, 58, 1'b0, 1'b0);

    // Reset while mem_en and MFC are both high
    @(negedge clk);
    req_rw = 1'b1; req_addr = 16'h0001; req_wdata = 16'h0000; req_valid = 1'b1;
    @(posedge clk);
    #1;
    dly_q.push_back(5);
    nev_q.push_back(1'b0);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_en", mem_en, 1'b1);
    check("pre_rst_mfc", mem_mfc, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_en", mem_en, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ready", req_ready, 1'b1);
    check("mid_rst_rsp", rsp_valid, 1'b0);
    reset = 1'b0;
    last_rdata = 16'h0000;
    issue(1'b1, 16'h0002, 16'h0000, 5, 1'b0, 1'b0);
    check("post_rst_rd", rsp_rdata, 16'h4102);

    // Random traffic
    n_rand = 40;
    for (int k = 0; k < n_rand; k++) begin
      gap   = $urandom_range(0, 2);
      rw_r  = 1'($urandom_range(0, 1));
      nev_r = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      issue(rw_r, 16'(16'h0020 + $urandom_range(0, 15)), 16'($urandom),
            $urandom_range(0, 5) * 10 + 5, nev_r, (gap == 0) && (k < n_rand - 1));
      repeat (gap) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("end_idle", busy, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case something above stops advancing.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_initiator.md
Name: mem_initiator

Overview:
- Clocked bus master that drives the asynchronous memory strobe interface: en, rw, addr, write data, and the MFC completion flag.
- Sits between the CPU control unit and the memory block.
- Accepts one read or write request at a time over a valid/ready handshake and sequences the en/MFC four-phase handshake.
- Synchronizes MFC into the clock domain and returns read data or completion status over a one-cycle response pulse, with timeout protection.

Parameters:
- AW, 16, address width
- DW, 16, data width
- TIMEOUT, 64, max cycles waited for an MFC edge before flagging error (>= 4)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; transfer on req_valid & req_ready
- req_rw  in  1  1 = read, 0 = write
- req_addr  in  AW  request address
- req_wdata  in  DW  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DW  read data, valid with rsp_valid on reads
- rsp_err  out  1  timeout flag, valid with rsp_valid
- busy  out  1  high in any state except IDLE
- mem_en  out  1  memory strobe; memory acts on its rising edge
- mem_rw  out  1  to memory rw
- mem_addr  out  AW  to memory addr
- mem_wdata  out  DW  to memory in
- mem_rdata  in  DW  from memory out
- mem_mfc  in  1  memory function complete; asynchronous, synchronized internally

Behaviour:
- Reset values: all outputs registered. On reset, mem_en, mem_rw, rsp_valid, rsp_err and busy go to 0; mem_addr, mem_wdata and rsp_rdata go to 0; req_ready goes to 1; state goes to IDLE; timeout counter and both synchronizer flops go to 0.
- MFC synchronization: 2-flop synchronizer produces mfc_s. Every decision uses mfc_s, never raw mem_mfc.
- IDLE:
  - req_ready=1.
  - On accept, latch req_rw/req_addr/req_wdata into mem_rw/mem_addr/mem_wdata and go to SETUP.
- SETUP:
  - mem_en=0, address/rw/data stable.
  - If mfc_s=0, go to STROBE and set mem_en=1.
  - Otherwise stay in SETUP (stale MFC, e.g. after reset mid-transfer).
- STROBE:
  - mem_en=1; the counter increments each cycle.
  - When mfc_s=1, capture mem_rdata into rsp_rdata (reads only; rsp_rdata unchanged on writes), clear mem_en, clear the counter and go to RELEASE.
  - If the counter reaches TIMEOUT-1 first, clear mem_en, set an internal err flag and go to RELEASE.
- RELEASE:
  - mem_en=0.
  - When mfc_s=0, go to RESP.
  - Timeout at TIMEOUT-1: set err and go to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle; rsp_err=err.
  - Next state IDLE, and err clears.
- Address/data hold: mem_addr, mem_rw and mem_wdata stay constant from SETUP through RESP; they change only on accept.
- No pipelining: one outstanding transfer. req_ready stays 0 from the accept edge until IDLE is re-entered.
- Nominal latency, with MFC rising and falling within one clock of mem_en edges:
  - Edge after accept: STROBE.
  - +3 edges: RELEASE.
  - +3 edges: RESP.
  - rsp_valid is high in the cycle after the 7th rising edge following the accepting edge.
- Simultaneous events:
  - req_valid while busy is ignored; the requester holds it.
  - reset overrides all.
  - In STROBE, an MFC edge and timeout in the same cycle resolve as success.
- Reset mid-operation: mem_en drops at that edge. Any still-high MFC is absorbed by the SETUP wait on the next request.
- Counter width: $clog2(TIMEOUT). It clears on entry to STROBE and to RELEASE.

Test Plan:
1. Write then read:
   - Stimulus: write req_addr=0x0010, req_wdata=0xBEEF, then read 0x0010, using a behavioural memory model with MFC 5ns after en rise and cleared on en fall, clk=10ns.
   - Required response: mem_en sees exactly one rising edge per transfer; the write shows rw=0, in=0xBEEF; the read returns rsp_rdata=0xBEEF with rsp_err=0; each rsp_valid comes 7 cycles after its accept.
2. Program-image read:
   - Stimulus: read addr 0x0000 from a model preloaded with 0x50A3.
   - Required response: rsp_rdata=0x50A3, and mem_addr holds 0x0000 from SETUP to RESP.
3. Back-to-back requests:
   - Stimulus: req_valid held high for 3 reads (0x0001, 0x0002, 0x0003).
   - Required response: exactly 3 accepts, req_ready low while busy, and rsp order/data match the addresses (0x0081, 0x4102, 0x111D).
4. Timeout:
   - Stimulus: model never raises MFC, TIMEOUT=8.
   - Required response: mem_en drops after 8 STROBE cycles; RELEASE exits immediately; rsp_valid=1 with rsp_err=1; the next good transfer has rsp_err=0.
5. Reset mid-STROBE:
   - Stimulus: assert reset for 1 cycle while mem_en=1 and MFC=1, then issue a read immediately.
   - Required response: mem_en=0 and busy=0 after the reset edge; the new request stalls in SETUP until mfc_s=0, then completes correctly.
6. Slow memory:
   - Stimulus: MFC delayed 35ns after en rise.
   - Required response: mem_en stays high until mfc_s=1, and the read data captured is the stable post-MFC value.
